// File: rtl/sh7604_ibus_master.sv
// SH7604 on-chip IBUS initiator: byte/word/long accesses, big-endian lanes, BUSY waits, ACT-based error.
// Define SH7604_IBUS_TIMEOUT_EN to abort a transaction after TO_LIMIT BUSY-extended LATCH edges.
module sh7604_ibus_master #(
  parameter int unsigned TO_LIMIT = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic [31:0] CPU_A,
  input  logic [31:0] CPU_DI,
  input  logic        CPU_WE,
  input  logic [1:0]  CPU_SZ,
  input  logic        CPU_REQ,
  output logic [31:0] CPU_DO,
  output logic        CPU_ACK,
  output logic        CPU_ERR,
  output logic [31:0] IBUS_A,
  output logic [31:0] IBUS_DO,
  output logic [3:0]  IBUS_BA,
  output logic        IBUS_WE,
  output logic        IBUS_REQ,
  input  logic [31:0] IBUS_DI,
  input  logic        IBUS_BUSY,
  input  logic        IBUS_ACT
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_LATCH, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  ba_q, ba_d;
  logic [1:0]  sz_q, sz_d;
  logic        we_q, we_d, err_q, err_d;
  logic        ce_f, misaligned, accept, busy_abort, ibus_req;

  // A coincident CE_R swallows CE_F.
  assign ce_f       = CE_F & ~CE_R;
  assign misaligned = ((CPU_SZ == 2'd1) & CPU_A[0]) | (CPU_SZ[1] & (|CPU_A[1:0]));
  assign accept     = (state_q == S_IDLE) & CE_R & CPU_REQ;

  function automatic logic [3:0] lane_ba(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'd0:    return 4'b1000 >> off;
      2'd1:    return off[1] ? 4'b0011 : 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] di);
    case (sz)
      2'd0:    return {4{di[7:0]}};
      2'd1:    return {2{di[15:0]}};
      default: return di;
    endcase
  endfunction

  function automatic logic [31:0] rd_extract(input logic [1:0] sz, input logic [1:0] off,
                                             input logic [31:0] di);
    case (sz)
      2'd0:    return {24'b0, 8'(di >> {~off, 3'b000})};
      2'd1:    return off[1] ? {16'b0, di[15:0]} : {16'b0, di[31:16]};
      default: return di;
    endcase
  endfunction

`ifdef SH7604_IBUS_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TO_LIMIT + 1) > 8) ? $clog2(TO_LIMIT + 1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;

  assign busy_abort = IBUS_BUSY && ((32'(cnt_q) + 32'd1) >= TO_LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (accept)
      cnt_d = '0;
    else if (state_q == S_LATCH && CE_R && IBUS_BUSY && !busy_abort)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
`else
  assign busy_abort = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = misaligned ? S_DONE : S_REQ;
      S_REQ:   if (ce_f) state_d = S_LATCH;
      S_LATCH: if (CE_R) state_d = (IBUS_BUSY && !busy_abort) ? S_REQ : S_DONE;
      S_DONE:  if (CE_R) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    wdata_d = wdata_q;
    ba_d    = ba_q;
    sz_d    = sz_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      a_d     = CPU_A;
      wdata_d = lane_wdata(CPU_SZ, CPU_DI);
      ba_d    = lane_ba(CPU_SZ, CPU_A[1:0]);
      sz_d    = CPU_SZ;
      we_d    = CPU_WE;
      err_d   = misaligned;
    end else if (state_q == S_LATCH && CE_R && (!IBUS_BUSY || busy_abort)) begin
      // Timeout and unclaimed accesses both complete with zeroed read data.
      if (busy_abort || !IBUS_ACT) begin
        rdata_d = '0;
        err_d   = 1'b1;
      end else begin
        err_d = 1'b0;
        if (!we_q) rdata_d = rd_extract(sz_q, a_q[1:0], IBUS_DI);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      a_q     <= '0;
      wdata_q <= '0;
      ba_q    <= '0;
      sz_q    <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      wdata_q <= wdata_d;
      ba_q    <= ba_d;
      sz_q    <= sz_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end

  // IBUS outputs are gated by the transaction state so they read zero between requests.
  always_comb begin
    ibus_req = (state_q == S_REQ) || (state_q == S_LATCH);
    IBUS_REQ = ibus_req;
    IBUS_A   = ibus_req ? a_q     : '0;
    IBUS_DO  = ibus_req ? wdata_q : '0;
    IBUS_BA  = ibus_req ? ba_q    : '0;
    IBUS_WE  = ibus_req & we_q;
    CPU_ACK  = (state_q == S_DONE);
    CPU_ERR  = (state_q == S_DONE) & err_q;
    CPU_DO   = rdata_q;
  end

endmodule

// File: tb/tb_sh7604_ibus_master.sv
// Self-checking bench for sh7604_ibus_master: directed test-plan cases plus randomized accesses
// checked against a byte-granular reference model.
module tb_sh7604_ibus_master;
  logic        CLK = 1'b0;
  logic        RST_N, CE_R, CE_F, CPU_WE, CPU_REQ, IBUS_BUSY, IBUS_ACT;
  logic [31:0] CPU_A, CPU_DI, IBUS_DI, CPU_DO, IBUS_A, IBUS_DO;
  logic [1:0]  CPU_SZ;
  logic [3:0]  IBUS_BA;
  logic        CPU_ACK, CPU_ERR, IBUS_WE, IBUS_REQ;

  int          checks = 0;
  int          failures = 0;
  int          wr_cnt = 0;
  logic [31:0] exp_do = '0;

  always #5 CLK = ~CLK;

  sh7604_ibus_master #(.TO_LIMIT(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F),
    .CPU_A(CPU_A), .CPU_DI(CPU_DI), .CPU_WE(CPU_WE), .CPU_SZ(CPU_SZ), .CPU_REQ(CPU_REQ),
    .CPU_DO(CPU_DO), .CPU_ACK(CPU_ACK), .CPU_ERR(CPU_ERR),
    .IBUS_A(IBUS_A), .IBUS_DO(IBUS_DO), .IBUS_BA(IBUS_BA), .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ),
    .IBUS_DI(IBUS_DI), .IBUS_BUSY(IBUS_BUSY), .IBUS_ACT(IBUS_ACT)
  );

  // Reference model: byte-granular view of a big-endian access of n bytes at offset off.
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] addr);
    return (int'(addr[1:0]) % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] m_ba(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] ba = '0;
    for (int k = int'(off); k < int'(off) + nbytes(sz); k++) ba[3-k] = 1'b1;
    return ba;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] di);
    logic [31:0] r = '0;
    int n = nbytes(sz);
    for (int k = 0; k < 4; k++) r[8*k +: 8] = di[8*(k % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rd(input logic [1:0] sz, input logic [1:0] off,
                                       input logic [31:0] di);
    int n = nbytes(sz);
    logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    return (di >> (8 * (4 - int'(off) - n))) & mask;
  endfunction

  // One clock with the given enables; responder write count taken before the edge.
  task automatic tick(input logic r, input logic f);
    @(negedge CLK);
    CE_R = r;
    CE_F = f;
    if (f && !r && IBUS_REQ && IBUS_WE) wr_cnt++;
    @(posedge CLK);
    #1;
  endtask

  task automatic ce_period_tail();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
  endtask

  task automatic access(input logic [31:0] addr, input logic [31:0] di, input logic we,
                        input logic [1:0] sz, input logic [31:0] rdi, input int busy_n,
                        input logic act, input string tag);
    logic [3:0]  e_ba;
    logic [31:0] e_wd;
    e_ba = m_ba(sz, addr[1:0]);
    e_wd = m_wd(sz, di);
    CPU_A = addr; CPU_DI = di; CPU_WE = we; CPU_SZ = sz; CPU_REQ = 1'b1;
    IBUS_BUSY = 1'b0; IBUS_ACT = act; IBUS_DI = rdi;
    wr_cnt = 0;
    tick(1'b1, 1'b0);
    CPU_REQ = 1'b0;
    if (m_mis(sz, addr)) begin
      checks++;
      if (IBUS_REQ !== 1'b0 || CPU_ACK !== 1'b1 || CPU_ERR !== 1'b1 || CPU_DO !== exp_do) begin
        failures++;
        $display("FAIL %s misaligned: req=%b ack=%b err=%b do=%h, want req=0 ack=1 err=1 do=%h",
                 tag, IBUS_REQ, CPU_ACK, CPU_ERR, CPU_DO, exp_do);
      end
      ce_period_tail();
      checks++;
      if (IBUS_REQ !== 1'b0 || wr_cnt != 0) begin
        failures++;
        $display("FAIL %s misaligned_bus: req=%b writes=%0d, want req=0 writes=0", tag, IBUS_REQ, wr_cnt);
      end
      tick(1'b1, 1'b0);
      checks++;
      if (CPU_ACK !== 1'b0) begin
        failures++;
        $display("FAIL %s misaligned_ack_len: ack=%b want 0", tag, CPU_ACK);
      end
      return;
    end
    checks++;
    if (IBUS_REQ !== 1'b1 || IBUS_A !== addr || IBUS_BA !== e_ba || IBUS_WE !== we ||
        IBUS_DO !== e_wd || CPU_ACK !== 1'b0) begin
      failures++;
      $display("FAIL %s issue: req=%b a=%h ba=%b we=%b do=%h ack=%b, want 1 %h %b %b %h 0",
               tag, IBUS_REQ, IBUS_A, IBUS_BA, IBUS_WE, IBUS_DO, CPU_ACK, addr, e_ba, we, e_wd);
    end
    for (int i = 0; i <= busy_n; i++) begin
      IBUS_BUSY = (i < busy_n);
      ce_period_tail();
      tick(1'b1, 1'b0);
      if (i < busy_n) begin
        checks++;
        if (IBUS_REQ !== 1'b1 || IBUS_A !== addr || IBUS_BA !== e_ba || IBUS_WE !== we ||
            IBUS_DO !== e_wd || CPU_ACK !== 1'b0) begin
          failures++;
          $display("FAIL %s busy_wait%0d: req=%b a=%h ba=%b we=%b do=%h ack=%b, want 1 %h %b %b %h 0",
                   tag, i, IBUS_REQ, IBUS_A, IBUS_BA, IBUS_WE, IBUS_DO, CPU_ACK, addr, e_ba, we, e_wd);
        end
      end
    end
    IBUS_BUSY = 1'b0;
    if (!act)     exp_do = '0;
    else if (!we) exp_do = m_rd(sz, addr[1:0], rdi);
    checks++;
    if (IBUS_REQ !== 1'b0 || CPU_ACK !== 1'b1 || CPU_ERR !== ~act || CPU_DO !== exp_do) begin
      failures++;
      $display("FAIL %s complete: req=%b ack=%b err=%b do=%h, want req=0 ack=1 err=%b do=%h",
               tag, IBUS_REQ, CPU_ACK, CPU_ERR, CPU_DO, ~act, exp_do);
    end
    checks++;
    if (wr_cnt != (we ? busy_n + 1 : 0)) begin
      failures++;
      $display("FAIL %s write_count: got=%0d want=%0d", tag, wr_cnt, we ? busy_n + 1 : 0);
    end
    ce_period_tail();
    checks++;
    if (CPU_ACK !== 1'b1 || IBUS_A !== '0 || IBUS_BA !== '0 || IBUS_DO !== '0 || IBUS_WE !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_bus: ack=%b a=%h ba=%b do=%h we=%b, want ack=1 and zero bus",
               tag, CPU_ACK, IBUS_A, IBUS_BA, IBUS_DO, IBUS_WE);
    end
    tick(1'b1, 1'b0);
    checks++;
    if (CPU_ACK !== 1'b0) begin
      failures++;
      $display("FAIL %s ack_len: ack=%b want 0", tag, CPU_ACK);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; CE_R = 1'b0; CE_F = 1'b0; CPU_A = '0; CPU_DI = '0; CPU_WE = 1'b0;
    CPU_SZ = '0; CPU_REQ = 1'b0; IBUS_DI = '0; IBUS_BUSY = 1'b0; IBUS_ACT = 1'b1;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    checks++;
    if (CPU_DO !== '0 || CPU_ACK !== 1'b0 || CPU_ERR !== 1'b0 || IBUS_A !== '0 || IBUS_DO !== '0 ||
        IBUS_BA !== '0 || IBUS_WE !== 1'b0 || IBUS_REQ !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: do=%h ack=%b err=%b a=%h ibdo=%h ba=%b we=%b req=%b, want all 0",
               CPU_DO, CPU_ACK, CPU_ERR, IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    exp_do = '0;
    ce_period_tail();
  endtask

  task automatic test_plan();
    access(32'hFFFF_FE10, 32'h0, 1'b0, 2'd2, 32'h1234_5678, 0, 1'b1, "long_read");
    checks++;
    if (CPU_DO !== 32'h1234_5678) begin
      failures++;
      $display("FAIL long_read_value: got=%h want=12345678", CPU_DO);
    end
    access(32'hFFFF_FE11, 32'h0000_00A5, 1'b1, 2'd0, 32'h0, 0, 1'b1, "byte_write");
    access(32'hFFFF_FE12, 32'h0, 1'b0, 2'd1, 32'hDEAD_BEEF, 0, 1'b1, "word_read_hi_off");
    checks++;
    if (CPU_DO !== 32'h0000_BEEF) begin
      failures++;
      $display("FAIL word_read_12: got=%h want=0000beef", CPU_DO);
    end
    access(32'hFFFF_FE10, 32'h0, 1'b0, 2'd1, 32'hDEAD_BEEF, 0, 1'b1, "word_read_lo_off");
    checks++;
    if (CPU_DO !== 32'h0000_DEAD) begin
      failures++;
      $display("FAIL word_read_10: got=%h want=0000dead", CPU_DO);
    end
    access(32'hFFFF_FE14, 32'hCAFE_F00D, 1'b1, 2'd2, 32'h0, 3, 1'b1, "busy3_write");
    access(32'hFFFF_FE02, 32'h0, 1'b0, 2'd2, 32'h0, 0, 1'b1, "long_misaligned");
    access(32'hFFFF_FE13, 32'h0, 1'b0, 2'd1, 32'h0, 0, 1'b1, "word_misaligned");
    access(32'h0000_4000, 32'h0, 1'b0, 2'd2, 32'h5555_AAAA, 0, 1'b0, "unclaimed_read");
  endtask

  task automatic test_same_edge();
    CPU_A = 32'hFFFF_FE20; CPU_WE = 1'b0; CPU_SZ = 2'd2; CPU_REQ = 1'b1;
    IBUS_DI = 32'h0BAD_F00D; IBUS_ACT = 1'b1; IBUS_BUSY = 1'b0;
    tick(1'b1, 1'b0);
    CPU_REQ = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    checks++;
    if (IBUS_REQ !== 1'b1 || CPU_ACK !== 1'b0) begin
      failures++;
      $display("FAIL same_edge_ignored: req=%b ack=%b, want req=1 ack=0", IBUS_REQ, CPU_ACK);
    end
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    exp_do = 32'h0BAD_F00D;
    checks++;
    if (CPU_ACK !== 1'b1 || CPU_DO !== exp_do) begin
      failures++;
      $display("FAIL same_edge_complete: ack=%b do=%h, want ack=1 do=%h", CPU_ACK, CPU_DO, exp_do);
    end
    tick(1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      logic [31:0] addr;
      logic [1:0]  sz;
      sz   = 2'($urandom_range(0, 3));
      addr = $urandom();
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(nbytes(sz) - 1);
      access(addr, $urandom(), 1'($urandom_range(0, 1)), sz, $urandom(),
             $urandom_range(0, 2), $urandom_range(0, 5) != 0, $sformatf("rand%0d", t));
    end
  endtask

`ifdef SH7604_IBUS_TIMEOUT_EN
  task automatic test_timeout();
    CPU_A = 32'hFFFF_FE30; CPU_WE = 1'b0; CPU_SZ = 2'd2; CPU_REQ = 1'b1;
    IBUS_DI = 32'h1111_2222; IBUS_ACT = 1'b1; IBUS_BUSY = 1'b1;
    tick(1'b1, 1'b0);
    CPU_REQ = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      ce_period_tail();
      tick(1'b1, 1'b0);
      checks++;
      if (CPU_ACK !== (i == 4) || IBUS_REQ !== (i != 4)) begin
        failures++;
        $display("FAIL timeout_edge%0d: ack=%b req=%b, want ack=%b req=%b",
                 i, CPU_ACK, IBUS_REQ, i == 4, i != 4);
      end
    end
    exp_do = '0;
    checks++;
    if (CPU_ERR !== 1'b1 || CPU_DO !== '0) begin
      failures++;
      $display("FAIL timeout_abort: err=%b do=%h, want err=1 do=0", CPU_ERR, CPU_DO);
    end
    IBUS_BUSY = 1'b0;
    tick(1'b1, 1'b0);
  endtask
`endif

  task automatic test_reset_mid();
    int acks = 0;
    CPU_A = 32'hFFFF_FE40; CPU_DI = 32'h77; CPU_WE = 1'b1; CPU_SZ = 2'd0; CPU_REQ = 1'b1;
    IBUS_BUSY = 1'b0; IBUS_ACT = 1'b1;
    tick(1'b1, 1'b0);
    CPU_REQ = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    exp_do = '0;
    checks++;
    if (IBUS_REQ !== 1'b0 || CPU_ACK !== 1'b0 || IBUS_A !== '0 || IBUS_WE !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_req: req=%b ack=%b a=%h we=%b, want all 0", IBUS_REQ, CPU_ACK, IBUS_A, IBUS_WE);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ce_period_tail();
      tick(1'b1, 1'b0);
      if (CPU_ACK === 1'b1 || IBUS_REQ === 1'b1) acks++;
    end
    checks++;
    if (acks != 0) begin
      failures++;
      $display("FAIL reset_mid_no_ack: active periods=%0d want 0", acks);
    end
  endtask

  initial begin
    test_reset();
    test_plan();
    test_same_edge();
    test_random();
`ifdef SH7604_IBUS_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
